// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment receive path:
//   - segment bit positions within the 7-bit pattern (a = bit6 ... g = bit0)
//   - the ten decimal segment patterns plus the BLANK pattern
//   - the 4-bit decoded code type (digits 0-9, BLANK, INVALID)
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment bit positions inside the 7-bit pattern.
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Normalised (segment on = 1) patterns, ordered abcdefg.
    localparam logic [6:0] PAT_0     = 7'b1111110;
    localparam logic [6:0] PAT_1     = 7'b0110000;
    localparam logic [6:0] PAT_2     = 7'b1101101;
    localparam logic [6:0] PAT_3     = 7'b1111001;
    localparam logic [6:0] PAT_4     = 7'b0110011;
    localparam logic [6:0] PAT_5     = 7'b1011011;
    localparam logic [6:0] PAT_6     = 7'b1011111;
    localparam logic [6:0] PAT_7     = 7'b1110000;
    localparam logic [6:0] PAT_8     = 7'b1111111;
    localparam logic [6:0] PAT_9     = 7'b1111011;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;

    typedef enum logic [3:0] {
        CODE_0       = 4'd0,
        CODE_1       = 4'd1,
        CODE_2       = 4'd2,
        CODE_3       = 4'd3,
        CODE_4       = 4'd4,
        CODE_5       = 4'd5,
        CODE_6       = 4'd6,
        CODE_7       = 4'd7,
        CODE_8       = 4'd8,
        CODE_9       = 4'd9,
        CODE_BLANK   = 4'd10,
        CODE_INVALID = 4'd15
    } code_t;

    // True when the code is a displayable decimal digit.
    function automatic logic is_decimal(input code_t code);
        return (code <= CODE_9);
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Multiplexed 7-segment display bus as seen by the scan decoder.
//   LED          : segment lines, abcdefg = bit6..bit0
//   LED_type_ctl : 0 = common cathode, 1 = common anode
//   DIG_EN       : one-hot digit enables (active high)
//   sample_en    : qualifies LED/DIG_EN for one clock
// master = display driver side, slave = scan decoder side.
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    logic [6:0]        LED;
    logic              LED_type_ctl;
    logic [DIGITS-1:0] DIG_EN;
    logic              sample_en;

    modport master (
        output LED,
        output LED_type_ctl,
        output DIG_EN,
        output sample_en
    );

    modport slave (
        input LED,
        input LED_type_ctl,
        input DIG_EN,
        input sample_en
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational strict decode of a normalised 7-segment pattern.
//   seg  : normalised pattern (segment on = 1), abcdefg = bit6..bit0
//   code : decimal digit, CODE_BLANK for all-off, CODE_INVALID otherwise
// -----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output code_t      code
);

    always_comb begin
        case (seg)
            PAT_0:     code = CODE_0;
            PAT_1:     code = CODE_1;
            PAT_2:     code = CODE_2;
            PAT_3:     code = CODE_3;
            PAT_4:     code = CODE_4;
            PAT_5:     code = CODE_5;
            PAT_6:     code = CODE_6;
            PAT_7:     code = CODE_7;
            PAT_8:     code = CODE_8;
            PAT_9:     code = CODE_9;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed 7-segment bus and reconstructs the BCD digit shown
// at each position. A digit is committed only after STABLE_CNT consecutive
// identical samples at that position.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : display bus (slave modport)
//   clr_err     : clears the sticky err flag (a new error in the same cycle wins)
//   BCD         : committed digits, digit i in [4i+3:4i]
//   digit_valid : position holds a committed decimal digit
//   update      : one-cycle pulse per commit
//   err         : sticky error (multi-hot DIG_EN or committed INVALID pattern)
// Pipeline: capture at edge k, evaluate/commit at edge k+1.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_decoder_if.slave    bus,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  err
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
    localparam int         SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Capture stage
    logic              s1_valid;
    logic [6:0]        s1_led;
    logic [DIGITS-1:0] s1_dig;
    logic              s1_type;

    // Polarity of the last evaluated one-hot sample
    logic              prev_type;

    // Per-position candidate and stability counter
    code_t             cand_q [DIGITS];
    code_t             cand_d [DIGITS];
    logic [3:0]        cnt_q  [DIGITS];
    logic [3:0]        cnt_d  [DIGITS];

    logic [4*DIGITS-1:0] bcd_d;
    logic [DIGITS-1:0]   valid_d;
    logic                upd_d;
    logic                err_set;

    logic [6:0]       seg;
    code_t            code;
    logic             one_hot;
    logic             multi_hot;
    logic             pol_flip;
    logic [SEL_W-1:0] sel;
    logic [3:0]       cnt_base;
    logic [3:0]       cnt_new;
    logic             commit;

    assign seg       = s1_type ? ~s1_led : s1_led;
    assign one_hot   = $onehot(s1_dig);
    assign multi_hot = (s1_dig != '0) && !one_hot;
    assign pol_flip  = s1_valid && one_hot && (s1_type != prev_type);

    seg7_pattern_decode u_decode (
        .seg  (seg),
        .code (code)
    );

    // Index of the enabled position (only meaningful when one_hot).
    always_comb begin
        sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s1_dig[i]) sel = SEL_W'(i);
        end
    end

    always_comb begin
        // NOTE: every combinationally written signal gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        bcd_d    = BCD;
        valid_d  = digit_valid;
        upd_d    = 1'b0;
        err_set  = 1'b0;
        cnt_base = '0;
        cnt_new  = '0;
        commit   = 1'b0;

        if (s1_valid && multi_hot) err_set = 1'b1;

        if (s1_valid && one_hot) begin
            // A polarity change restarts every count; committed outputs stay.
            if (pol_flip) begin
                for (int i = 0; i < DIGITS; i++) cnt_d[i] = '0;
            end
            cnt_base = pol_flip ? 4'd0 : cnt_q[sel];

            if (code == cand_q[sel]) begin
                cnt_new = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 4'd1;
                // Commit only on the transition into saturation.
                commit  = (cnt_new == CNT_MAX) && (cnt_base != CNT_MAX);
            end else begin
                cand_d[sel] = code;
                cnt_new     = 4'd1;
                commit      = (CNT_MAX == 4'd1);
            end
            cnt_d[sel] = cnt_new;

            if (commit) begin
                upd_d = 1'b1;
                if (is_decimal(code)) begin
                    bcd_d[4*sel +: 4] = code;
                    valid_d[sel]      = 1'b1;
                end else begin
                    valid_d[sel]      = 1'b0;
                end
                if (code == CODE_INVALID) err_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_led      <= '0;
            s1_dig      <= '0;
            s1_type     <= 1'b0;
            prev_type   <= 1'b0;
            // NOTE: the candidate/counter array is functional state (a stale
            // candidate would shorten the next commit), so it must be reset
            // element by element rather than left to power-up values.
            for (int i = 0; i < DIGITS; i++) begin
                cand_q[i] <= CODE_BLANK;
                cnt_q[i]  <= '0;
            end
            BCD         <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            s1_valid <= bus.sample_en;
            if (bus.sample_en) begin
                s1_led  <= bus.LED;
                s1_dig  <= bus.DIG_EN;
                s1_type <= bus.LED_type_ctl;
            end
            if (s1_valid && one_hot) prev_type <= s1_type;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            BCD         <= bcd_d;
            digit_valid <= valid_d;
            update      <= upd_d;
            if (err_set)      err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Table-driven bench for seg7_scan_decoder (DIGITS=4, STABLE_CNT=3). Each row
// is one sample followed by an idle evaluation cycle, then the outputs are
// compared. Back-to-back streaming and reset-mid-sequence are hand-written.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_err;
    logic [15:0] BCD;
    logic [3:0]  digit_valid;
    logic        update;
    logic        err;

    int checks   = 0;
    int failures = 0;

    seg7_scan_decoder_if #(.DIGITS(4)) bus ();

    seg7_scan_decoder #(.DIGITS(4), .STABLE_CNT(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clr_err     (clr_err),
        .BCD         (BCD),
        .digit_valid (digit_valid),
        .update      (update),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [6:0]  led;
        logic [3:0]  dig;
        logic        typ;
        logic        clr;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_valid;
        logic        exp_upd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic [6:0] led,
                                input logic [3:0] dig, input logic typ,
                                input logic clr, input logic [15:0] b,
                                input logic [3:0] v, input logic u,
                                input logic e);
        vec_t r;
        r.en = en; r.led = led; r.dig = dig; r.typ = typ; r.clr = clr;
        r.exp_bcd = b; r.exp_valid = v; r.exp_upd = u; r.exp_err = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] b,
                              input logic [3:0] v, input logic u,
                              input logic e);
        check({tag, ".bcd"},   32'(BCD),         32'(b));
        check({tag, ".valid"}, 32'(digit_valid), 32'(v));
        check({tag, ".update"},32'(update),      32'(u));
        check({tag, ".err"},   32'(err),         32'(e));
    endtask

    task automatic apply_row(input int idx, input vec_t r);
        bus.LED          = r.led;
        bus.DIG_EN       = r.dig;
        bus.LED_type_ctl = r.typ;
        bus.sample_en    = r.en;
        clr_err          = 1'b0;
        tick();
        bus.sample_en    = 1'b0;
        clr_err          = r.clr;
        tick();
        clr_err          = 1'b0;
        check_outs($sformatf("row%0d", idx), r.exp_bcd, r.exp_valid,
                   r.exp_upd, r.exp_err);
    endtask

    initial begin
        rst              = 1'b1;
        clr_err          = 1'b0;
        bus.LED          = '0;
        bus.DIG_EN       = '0;
        bus.LED_type_ctl = 1'b0;
        bus.sample_en    = 1'b0;

        // Common cathode, digit 0 shows 3
        vecs.push_back(mk(1, 7'b1111001, 4'b0001, 0, 0, 16'h0000, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 7'b1111001, 4'b0001, 0, 0, 16'h0000, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 7'b1111001, 4'b0001, 0, 0, 16'h0003, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 7'b1111001, 4'b0001, 0, 0, 16'h0003, 4'b0001, 0, 0));
        // Common anode: 5,7,8,9 on digits 0..3
        vecs.push_back(mk(1, 7'b0100100, 4'b0001, 1, 0, 16'h0003, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 7'b0100100, 4'b0001, 1, 0, 16'h0003, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 7'b0100100, 4'b0001, 1, 0, 16'h0005, 4'b0001, 1, 0));
        vecs.push_back(mk(1, 7'b0001111, 4'b0010, 1, 0, 16'h0005, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 7'b0001111, 4'b0010, 1, 0, 16'h0005, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 7'b0001111, 4'b0010, 1, 0, 16'h0075, 4'b0011, 1, 0));
        vecs.push_back(mk(1, 7'b0000000, 4'b0100, 1, 0, 16'h0075, 4'b0011, 0, 0));
        vecs.push_back(mk(1, 7'b0000000, 4'b0100, 1, 0, 16'h0075, 4'b0011, 0, 0));
        vecs.push_back(mk(1, 7'b0000000, 4'b0100, 1, 0, 16'h0875, 4'b0111, 1, 0));
        vecs.push_back(mk(1, 7'b0000100, 4'b1000, 1, 0, 16'h0875, 4'b0111, 0, 0));
        vecs.push_back(mk(1, 7'b0000100, 4'b1000, 1, 0, 16'h0875, 4'b0111, 0, 0));
        vecs.push_back(mk(1, 7'b0000100, 4'b1000, 1, 0, 16'h9875, 4'b1111, 1, 0));
        // Glitch rejection on digit 1: 1,1,2,2,2 commits only 2
        vecs.push_back(mk(1, 7'b0110000, 4'b0010, 0, 0, 16'h9875, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b0110000, 4'b0010, 0, 0, 16'h9875, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b1101101, 4'b0010, 0, 0, 16'h9875, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b1101101, 4'b0010, 0, 0, 16'h9875, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b1101101, 4'b0010, 0, 0, 16'h9825, 4'b1111, 1, 0));
        // Invalid pattern on digit 2
        vecs.push_back(mk(1, 7'b1000001, 4'b0100, 0, 0, 16'h9825, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b1000001, 4'b0100, 0, 0, 16'h9825, 4'b1111, 0, 0));
        vecs.push_back(mk(1, 7'b1000001, 4'b0100, 0, 0, 16'h9825, 4'b1011, 1, 1));
        // clr_err, multi-hot error, clr, clr coincident with new error, clr
        vecs.push_back(mk(0, 7'b0000000, 4'b0000, 0, 1, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b1111110, 4'b0110, 0, 0, 16'h9825, 4'b1011, 0, 1));
        vecs.push_back(mk(0, 7'b0000000, 4'b0000, 0, 1, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b1111110, 4'b0110, 0, 1, 16'h9825, 4'b1011, 0, 1));
        vecs.push_back(mk(0, 7'b0000000, 4'b0000, 0, 1, 16'h9825, 4'b1011, 0, 0));
        // Blanking interval sample has no effect
        vecs.push_back(mk(1, 7'b0110000, 4'b0000, 0, 0, 16'h9825, 4'b1011, 0, 0));
        // Polarity flip after two matching samples restarts the count
        vecs.push_back(mk(1, 7'b0110011, 4'b0001, 0, 0, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b0110011, 4'b0001, 0, 0, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b1001100, 4'b0001, 1, 0, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b1001100, 4'b0001, 1, 0, 16'h9825, 4'b1011, 0, 0));
        vecs.push_back(mk(1, 7'b1001100, 4'b0001, 1, 0, 16'h9824, 4'b1011, 1, 0));

        tick();
        tick();
        rst = 1'b0;
        check_outs("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) apply_row(i, vecs[i]);

        // Continuous sample_en: anode 0 on digit 3, four back-to-back samples.
        bus.LED          = 7'b0000001;
        bus.DIG_EN       = 4'b1000;
        bus.LED_type_ctl = 1'b1;
        bus.sample_en    = 1'b1;
        tick();
        check("stream.t1.update", 32'(update), 32'd0);
        tick();
        check("stream.t2.update", 32'(update), 32'd0);
        tick();
        check("stream.t3.update", 32'(update), 32'd0);
        tick();
        check("stream.t4.update", 32'(update), 32'd1);
        check("stream.t4.bcd",    32'(BCD),    32'h0824);
        bus.sample_en = 1'b0;
        tick();
        check("stream.t5.update", 32'(update), 32'd0);
        tick();
        check_outs("stream.end", 16'h0824, 4'b1011, 1'b0, 1'b0);

        // Reset mid-sequence: two samples of 6 on digit 1, third in flight.
        apply_row(100, mk(1, 7'b1011111, 4'b0010, 0, 0, 16'h0824, 4'b1011, 0, 0));
        apply_row(101, mk(1, 7'b1011111, 4'b0010, 0, 0, 16'h0824, 4'b1011, 0, 0));
        bus.sample_en = 1'b1;
        tick();
        bus.sample_en = 1'b0;
        rst           = 1'b1;
        tick();
        rst           = 1'b0;
        check_outs("midrst", 16'h0000, 4'b0000, 1'b0, 1'b0);
        tick();
        check("midrst.idle.update", 32'(update), 32'd0);
        apply_row(102, mk(1, 7'b1011111, 4'b0010, 0, 0, 16'h0000, 4'b0000, 0, 0));
        apply_row(103, mk(1, 7'b1011111, 4'b0010, 0, 0, 16'h0000, 4'b0000, 0, 0));
        apply_row(104, mk(1, 7'b1011111, 4'b0010, 0, 0, 16'h0060, 4'b0010, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
